// File: rtl/seq_decoder_if.sv
// Bundle between the sequencing decoder and its neighbours: the instruction memory,
// the run-control source, and the PE array / dot unit / data BRAM consumers.
interface seq_decoder_if #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 4,
  parameter int OP_SEL_WIDTH   = 2
) ();
  logic                                  start;
  logic [INS_ADDR_WIDTH-1:0]             start_pc;
  logic                                  issue_en;
  logic                                  stall;
  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  instruction;
  logic [INS_ADDR_WIDTH-1:0]             pc;
  logic [ADDR_WIDTH-1:0]                 a_addr;
  logic [ADDR_WIDTH-1:0]                 b_addr;
  logic [ADDR_WIDTH-1:0]                 r_addr;
  logic [OP_SEL_WIDTH-1:0]               pe_op;
  logic [1:0]                            dot_ctrl;
  logic                                  write_en;
  logic                                  r_select;
  logic                                  busy;
  logic                                  done;
  logic                                  err;

  modport slave (
    input  start, start_pc, issue_en, stall, instruction,
    output pc, a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en, r_select, busy, done, err
  );

  modport master (
    output start, start_pc, issue_en, stall, instruction,
    input  pc, a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en, r_select, busy, done, err
  );
endinterface

// File: rtl/seq_decoder.sv
// Fetch-sequencing SIMD instruction decoder: start/busy/done run control, stall,
// JUMP/HALT, one level of hardware LOOP/ENDLOOP and a sticky error flag.
module seq_decoder #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 4,
  parameter int OP_SEL_WIDTH   = 2,
  parameter int LOOP_CNT_WIDTH = ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_decoder_if.slave bus
);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP       = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD       = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB       = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL       = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_DOT_SHIFT = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_DOT_ACC   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_DOT_CLR   = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_PASS_B    = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOOP      = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_ENDLOOP   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP      = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT      = OPCODE_WIDTH'(15);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  state_t                    state, state_next;
  logic [INS_ADDR_WIDTH-1:0] pc, pc_next, pc_inc;
  logic [INS_ADDR_WIDTH-1:0] loop_start, loop_start_next;
  logic [LOOP_CNT_WIDTH-1:0] loop_cnt, loop_cnt_next, loop_init;
  logic                      loop_active, loop_active_next;
  logic                      err, err_next;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [ADDR_WIDTH-1:0]     a_field, b_field, r_field;
  logic                      step;
  logic [OP_SEL_WIDTH-1:0]   pe_op;
  logic [1:0]                dot_ctrl;
  logic                      write_en, r_select, done;

  assign opcode  = bus.instruction[OPCODE_WIDTH-1:0];
  assign r_field = bus.instruction[OPCODE_WIDTH +: ADDR_WIDTH];
  assign b_field = bus.instruction[OPCODE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
  assign a_field = bus.instruction[OPCODE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];

  assign step   = (state == RUN) && bus.issue_en && !bus.stall;
  assign pc_inc = pc + INS_ADDR_WIDTH'(1);
  // A zero repeat count still runs the body once.
  assign loop_init = (LOOP_CNT_WIDTH'(a_field) == '0) ? LOOP_CNT_WIDTH'(1)
                                                       : LOOP_CNT_WIDTH'(a_field);

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    loop_start_next  = loop_start;
    loop_cnt_next    = loop_cnt;
    loop_active_next = loop_active;
    err_next         = err;
    pe_op            = '0;
    dot_ctrl         = 2'b00;
    write_en         = 1'b0;
    r_select         = 1'b0;
    done             = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_next       = RUN;
          pc_next          = bus.start_pc;
          err_next         = 1'b0;
          loop_active_next = 1'b0;
        end
      end
      RUN: begin
        if (step) begin
          pc_next = pc_inc;
          case (opcode)
            OP_NOP:       ;
            OP_ADD:       begin pe_op = OP_SEL_WIDTH'(1); write_en = 1'b1; end
            OP_SUB:       begin pe_op = OP_SEL_WIDTH'(2); write_en = 1'b1; end
            OP_MUL:       begin pe_op = OP_SEL_WIDTH'(3); write_en = 1'b1; end
            OP_DOT_SHIFT: begin pe_op = OP_SEL_WIDTH'(3); write_en = 1'b1; r_select = 1'b1; dot_ctrl = 2'b01; end
            OP_DOT_ACC:   begin pe_op = OP_SEL_WIDTH'(3); write_en = 1'b1; r_select = 1'b1; dot_ctrl = 2'b10; end
            OP_DOT_CLR:   begin write_en = 1'b1; r_select = 1'b1; dot_ctrl = 2'b11; end
            OP_PASS_B:    write_en = 1'b1;
            OP_LOOP: begin
              // Only one loop level exists; a nested LOOP is flagged and skipped.
              if (loop_active) begin
                err_next = 1'b1;
              end else begin
                loop_start_next  = pc_inc;
                loop_cnt_next    = loop_init;
                loop_active_next = 1'b1;
              end
            end
            OP_ENDLOOP: begin
              if (loop_active && (loop_cnt > LOOP_CNT_WIDTH'(1))) begin
                loop_cnt_next = loop_cnt - LOOP_CNT_WIDTH'(1);
                pc_next       = loop_start;
              end else begin
                loop_active_next = 1'b0;
              end
            end
            OP_JUMP: pc_next = INS_ADDR_WIDTH'(r_field);
            OP_HALT: begin
              pc_next    = pc;
              state_next = HALTED;
              done       = 1'b1;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      loop_start  <= '0;
      loop_cnt    <= '0;
      loop_active <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      loop_start  <= loop_start_next;
      loop_cnt    <= loop_cnt_next;
      loop_active <= loop_active_next;
      err         <= err_next;
    end
  end

  assign bus.pc       = pc;
  assign bus.a_addr   = a_field;
  assign bus.b_addr   = b_field;
  assign bus.r_addr   = r_field;
  assign bus.pe_op    = pe_op;
  assign bus.dot_ctrl = dot_ctrl;
  assign bus.write_en = write_en;
  assign bus.r_select = r_select;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done;
  assign bus.err      = err;
endmodule

// File: tb/tb_seq_decoder.sv
// Testbench for seq_decoder: directed program scenarios plus randomized programs and
// control inputs checked against an instruction-level interpreter of the decoder.
module tb_seq_decoder;
  localparam int IAW = 10;
  localparam int AW  = 10;
  localparam int OW  = 4;
  localparam int OSW = 2;
  localparam int IW  = OW + 3*AW;
  localparam int NOP = 0, ADD = 1, MUL = 3, DOT_ACC = 5;
  localparam int LOOP = 8, ENDLOOP = 9, JUMP = 10, HALT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_decoder_if #(.INS_ADDR_WIDTH(IAW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .OP_SEL_WIDTH(OSW)) bus ();
  seq_decoder #(.INS_ADDR_WIDTH(IAW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .OP_SEL_WIDTH(OSW),
                .LOOP_CNT_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [IW-1:0] imem [0:1023];
  assign bus.instruction = imem[bus.pc];

  int vectors = 0;
  int errors  = 0;

  // Opcode -> (pe_op, write_en, r_select, dot_ctrl) table for the reference model
  logic [1:0] t_pe  [16] = '{2'd0,2'd1,2'd2,2'd3,2'd3,2'd3,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};
  logic       t_we  [16] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  logic       t_rs  [16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  logic [1:0] t_dot [16] = '{2'd0,2'd0,2'd0,2'd0,2'd1,2'd2,2'd3,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};

  // Reference model state: mode 0 idle, 1 running, 2 halted
  int         m_mode, m_cnt;
  logic [9:0] m_pc, m_ls;
  bit         m_la, m_err;

  function automatic logic [IW-1:0] mk(int op, int a, int b, int r);
    logic [IW-1:0] w;
    w = '0;
    w[OW-1:0]         = OW'(op);
    w[OW +: AW]       = AW'(r);
    w[OW+AW +: AW]    = AW'(b);
    w[OW+2*AW +: AW]  = AW'(a);
    return w;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) imem[i] = '0;
  endtask

  task automatic launch(input int spc);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_pc = IAW'(spc);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic model_commit(input bit r, input bit st, input logic [9:0] spc, input bit iss, input bit stl);
    logic [IW-1:0] w;
    int op, a;
    logic [9:0] nxt;
    if (r) begin
      m_mode = 0; m_pc = '0; m_ls = '0; m_cnt = 0; m_la = 0; m_err = 0;
    end else if (m_mode != 1) begin
      if (st) begin m_mode = 1; m_pc = spc; m_err = 0; m_la = 0; end
    end else if (iss && !stl) begin
      w   = imem[m_pc];
      op  = int'(w[OW-1:0]);
      a   = int'(w[OW+2*AW +: AW]);
      nxt = m_pc + 10'd1;
      if (op == LOOP) begin
        if (m_la) m_err = 1;
        else begin m_ls = nxt; m_cnt = (a == 0) ? 1 : a; m_la = 1; end
      end else if (op == ENDLOOP) begin
        if (m_la && m_cnt > 1) begin m_cnt--; nxt = m_ls; end
        else m_la = 0;
      end else if (op == JUMP) begin
        nxt = w[OW +: AW];
      end else if (op == HALT) begin
        nxt = m_pc; m_mode = 2;
      end else if (op >= 11 && op <= 14) begin
        m_err = 1;
      end
      m_pc = nxt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (bus.pc !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.pc); end
    vectors++;
    if ({bus.busy, bus.done, bus.err} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: busy/done/err got %b want 000", {bus.busy, bus.done, bus.err}); end
    vectors++;
    if ({bus.pe_op, bus.dot_ctrl, bus.write_en, bus.r_select} !== 6'd0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {bus.pe_op, bus.dot_ctrl, bus.write_en, bus.r_select}); end
    rst = 1'b0;
  endtask

  task automatic test_start_add();
    clear_mem();
    imem[5] = mk(ADD, 1, 2, 3);
    imem[6] = mk(ADD, 4, 5, 6);
    imem[7] = mk(HALT, 0, 0, 0);
    bus.issue_en = 1'b1; bus.stall = 1'b0;
    launch(5);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.pc, bus.write_en, bus.pe_op, bus.a_addr} !== {1'b1, 10'd5, 1'b1, 2'd1, 10'd1})
      begin errors++; $display("FAIL start_first: busy=%b pc=%0h we=%b pe=%0d a=%0h want 1 5 1 1 1", bus.busy, bus.pc, bus.write_en, bus.pe_op, bus.a_addr); end
    cyc();
    vectors++;
    if ({bus.pc, bus.write_en, bus.pe_op, bus.r_addr} !== {10'd6, 1'b1, 2'd1, 10'd6})
      begin errors++; $display("FAIL start_second: pc=%0h we=%b pe=%0d r=%0h want 6 1 1 6", bus.pc, bus.write_en, bus.pe_op, bus.r_addr); end
    cyc();
    vectors++;
    if ({bus.pc, bus.write_en, bus.done} !== {10'd7, 1'b0, 1'b1})
      begin errors++; $display("FAIL start_halt: pc=%0h we=%b done=%b want 7 0 1", bus.pc, bus.write_en, bus.done); end
    cyc();
    vectors++;
    if ({bus.pc, bus.busy, bus.done} !== {10'd7, 1'b0, 1'b0})
      begin errors++; $display("FAIL start_halted: pc=%0h busy=%b done=%b want 7 0 0", bus.pc, bus.busy, bus.done); end
  endtask

  task automatic test_issue_toggle();
    logic [9:0] e_pc   [6] = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd2, 10'd2};
    logic       e_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int writes = 0, dones = 0;
    clear_mem();
    imem[0] = mk(ADD, 0, 0, 0);
    imem[1] = mk(MUL, 0, 0, 0);
    imem[2] = mk(HALT, 0, 0, 0);
    bus.issue_en = 1'b1;
    launch(0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus.issue_en = (c % 2 == 0);
      @(negedge clk);
      if (bus.write_en) writes++;
      if (bus.done) dones++;
      vectors++;
      if ({bus.pc, bus.busy, bus.done, bus.write_en} !== {e_pc[c], e_busy[c], e_done[c], e_we[c]})
        begin errors++; $display("FAIL toggle_c%0d: pc=%0h busy=%b done=%b we=%b want %0h %b %b %b", c, bus.pc, bus.busy, bus.done, bus.write_en, e_pc[c], e_busy[c], e_done[c], e_we[c]); end
    end
    bus.issue_en = 1'b1;
    vectors++;
    if (writes !== 2) begin errors++; $display("FAIL toggle_writes: got %0d want 2", writes); end
    vectors++;
    if (dones !== 1) begin errors++; $display("FAIL toggle_dones: got %0d want 1", dones); end
  endtask

  task automatic test_loop();
    logic [9:0] e_pc  [9] = '{10'd0, 10'd1, 10'd2, 10'd1, 10'd2, 10'd1, 10'd2, 10'd3, 10'd3};
    logic [1:0] e_dot [9] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    int accs = 0;
    clear_mem();
    imem[0] = mk(LOOP, 3, 0, 0);
    imem[1] = mk(DOT_ACC, 7, 8, 9);
    imem[2] = mk(ENDLOOP, 0, 0, 0);
    imem[3] = mk(HALT, 0, 0, 0);
    launch(0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (bus.dot_ctrl == 2'b10 && bus.r_select) accs++;
      vectors++;
      if ({bus.pc, bus.busy, bus.dot_ctrl, bus.r_select} !== {e_pc[c], (c < 8), e_dot[c], (e_dot[c] != 2'd0)})
        begin errors++; $display("FAIL loop_c%0d: pc=%0h busy=%b dot=%b rs=%b want pc=%0h dot=%b", c, bus.pc, bus.busy, bus.dot_ctrl, bus.r_select, e_pc[c], e_dot[c]); end
    end
    vectors++;
    if (accs !== 3) begin errors++; $display("FAIL loop_acc_count: got %0d want 3", accs); end
  endtask

  task automatic test_stall();
    clear_mem();
    imem[4] = mk(MUL, 0, 0, 0);
    imem[5] = mk(HALT, 0, 0, 0);
    bus.stall = 1'b1;
    launch(4);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      vectors++;
      if ({bus.pc, bus.write_en, bus.busy} !== {10'd4, 1'b0, 1'b1})
        begin errors++; $display("FAIL stall_hold_c%0d: pc=%0h we=%b busy=%b want 4 0 1", c, bus.pc, bus.write_en, bus.busy); end
    end
    @(posedge clk); #1;
    bus.stall = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.pc, bus.write_en, bus.pe_op} !== {10'd4, 1'b1, 2'd3})
      begin errors++; $display("FAIL stall_release: pc=%0h we=%b pe=%0d want 4 1 3", bus.pc, bus.write_en, bus.pe_op); end
    cyc();
    vectors++;
    if ({bus.pc, bus.write_en, bus.done} !== {10'd5, 1'b0, 1'b1})
      begin errors++; $display("FAIL stall_next: pc=%0h we=%b done=%b want 5 0 1", bus.pc, bus.write_en, bus.done); end
    cyc();
  endtask

  task automatic test_illegal_jump();
    clear_mem();
    imem[0]  = mk(12, 0, 0, 0);
    imem[1]  = mk(JUMP, 0, 0, 10'h3FF);
    imem[16] = mk(HALT, 0, 0, 0);
    launch(0);
    @(negedge clk);
    vectors++;
    if ({bus.pc, bus.err, bus.write_en} !== {10'd0, 1'b0, 1'b0})
      begin errors++; $display("FAIL illegal_exec: pc=%0h err=%b we=%b want 0 0 0", bus.pc, bus.err, bus.write_en); end
    cyc();
    vectors++;
    if ({bus.pc, bus.err} !== {10'd1, 1'b1})
      begin errors++; $display("FAIL illegal_err: pc=%0h err=%b want 1 1", bus.pc, bus.err); end
    cyc();
    vectors++;
    if ({bus.pc, bus.err} !== {10'h3FF, 1'b1})
      begin errors++; $display("FAIL jump_target: pc=%0h err=%b want 3ff 1", bus.pc, bus.err); end
    @(posedge clk); #1;
    imem[0] = mk(HALT, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if ({bus.pc, bus.err, bus.done} !== {10'd0, 1'b1, 1'b1})
      begin errors++; $display("FAIL wrap: pc=%0h err=%b done=%b want 0 1 1", bus.pc, bus.err, bus.done); end
    cyc();
    vectors++;
    if ({bus.busy, bus.err} !== {1'b0, 1'b1})
      begin errors++; $display("FAIL err_sticky: busy=%b err=%b want 0 1", bus.busy, bus.err); end
    launch(16);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.err, bus.pc} !== {1'b1, 1'b0, 10'd16})
      begin errors++; $display("FAIL start_clears_err: busy=%b err=%b pc=%0h want 1 0 10", bus.busy, bus.err, bus.pc); end
    cyc();
  endtask

  task automatic test_reset_midloop();
    int n = 0, writes = 0;
    bit seen = 0;
    clear_mem();
    imem[0] = mk(LOOP, 3, 0, 0);
    imem[1] = mk(ADD, 0, 0, 0);
    imem[2] = mk(ENDLOOP, 0, 0, 0);
    imem[3] = mk(HALT, 0, 0, 0);
    launch(0);
    @(negedge clk);
    cyc();
    cyc();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.pc, bus.done} !== {10'd1, 1'b0})
      begin errors++; $display("FAIL midloop_pre: pc=%0h done=%b want 1 0", bus.pc, bus.done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.pc, bus.done, bus.err} !== {1'b0, 10'd0, 1'b0, 1'b0})
      begin errors++; $display("FAIL midloop_reset: busy=%b pc=%0h done=%b err=%b want 0 0 0 0", bus.busy, bus.pc, bus.done, bus.err); end
    launch(0);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (bus.write_en) writes++;
      if (bus.done) begin seen = 1; n = c; end
    end
    vectors++;
    if (!seen || n != 7) begin errors++; $display("FAIL restart_done: seen=%0d cycle=%0d want 1 7", seen, n); end
    vectors++;
    if (writes != 3) begin errors++; $display("FAIL restart_writes: got %0d want 3", writes); end
  endtask

  task automatic test_random();
    logic [38:0]   got, expv;
    logic [IW-1:0] w;
    logic [3:0]    op;
    bit            busy_e, step_e;
    for (int i = 0; i < 1024; i++) begin
      op = 4'($urandom_range(0, 15));
      imem[i] = mk(int'(op), $urandom_range(0, 4), $urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_commit(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.start_pc = IAW'($urandom_range(0, 1023));
      bus.issue_en = ($urandom_range(0, 3) != 0);
      bus.stall    = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      busy_e = (m_mode == 1);
      step_e = busy_e && bus.issue_en && !bus.stall;
      w      = imem[m_pc];
      op     = w[OW-1:0];
      expv = {m_pc, busy_e, step_e && (op == 4'(HALT)), m_err,
              step_e ? t_we[op] : 1'b0, step_e ? t_pe[op] : 2'd0,
              step_e ? t_dot[op] : 2'd0, step_e ? t_rs[op] : 1'b0,
              w[OW+2*AW +: AW], w[OW +: AW]};
      got  = {bus.pc, bus.busy, bus.done, bus.err, bus.write_en, bus.pe_op,
              bus.dot_ctrl, bus.r_select, bus.a_addr, bus.r_addr};
      vectors++;
      if (got !== expv) begin
        errors++;
        $display("FAIL random_c%0d: got %h want %h (pc,busy,done,err,we,pe,dot,rs,a,r)", i, got, expv);
      end
      model_commit(rst, bus.start, bus.start_pc, bus.issue_en, bus.stall);
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.start_pc = '0; bus.issue_en = 1'b1; bus.stall = 1'b0;
    clear_mem();
    test_reset();
    test_start_add();
    test_issue_toggle();
    test_loop();
    test_stall();
    test_illegal_jump();
    test_reset_midloop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "time limit");
  end
endmodule
